dpram_port_arb: RTL

Round-robin arbiter that shares one dpram port (data/addr/we/valid/ready/q) between NUM_REQ requesters. It registers the winning request into a single-entry output stage and drives the dpram port with a valid/ready handshake. Read data is returned to the issuing requester after RD_LAT cycles using an in-flight ID pipeline. One instance sits in front of each dpram port.

---
 rtl/dpram_port_arb_pkg.sv | 20 ++
 rtl/dpram_port_arb_if.sv | 29 ++
 rtl/dpram_port_arb_rr_arbiter.sv | 26 ++
 rtl/dpram_port_arb.sv | 132 +++++++++++++
 4 files changed

// File: rtl/dpram_port_arb_pkg.sv
// Shared types and constants for the dpram port arbiter.
package dpram_arb_pkg;
   localparam int NUM_REQ_DEF = 4;
   localparam int ADDR_W_DEF  = 8;
   localparam int DATA_W_DEF  = 8;
   localparam int PERF_CNT_W  = 16;

   typedef logic [$clog2(NUM_REQ_DEF)-1:0] req_id_t;

   typedef struct packed {
      logic                  we;
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] data;
      req_id_t               id;
   } mem_req_s;

   function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction
endpackage

// File: rtl/dpram_port_arb_if.sv
// Requester + dpram port bundle; slave = arbiter view, master = environment view.
interface dpram_port_arb_if #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ-1:0]        req_we;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [DATA_W-1:0]         rsp_data;
   logic                      mem_valid;
   logic                      mem_ready;
   logic                      mem_we;
   logic [ADDR_W-1:0]         mem_addr;
   logic [DATA_W-1:0]         mem_data;
   logic [DATA_W-1:0]         mem_q;

   modport slave (
      input  req_valid, req_we, req_addr, req_data, mem_ready, mem_q,
      output req_ready, rsp_valid, rsp_data, mem_valid, mem_we, mem_addr, mem_data
   );
   modport master (
      output req_valid, req_we, req_addr, req_data, mem_ready, mem_q,
      input  req_ready, rsp_valid, rsp_data, mem_valid, mem_we, mem_addr, mem_data
   );
endinterface

// File: rtl/dpram_port_arb_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above i_ptr, wrapping.
module rr_arbiter #(
   parameter int N = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);
   // Scan from farthest to nearest so the nearest hit to i_ptr wins.
   always_comb begin
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      for (int k = N-1; k >= 0; k--) begin
         if (i_req[(int'(i_ptr) + k) % N]) begin
            o_gnt                         = '0;
            o_gnt[(int'(i_ptr) + k) % N] = 1'b1;
            o_idx                         = IW'((int'(i_ptr) + k) % N);
            o_any                         = 1'b1;
         end
      end
   end
endmodule

// File: rtl/dpram_port_arb.sv
// Round-robin dpram port arbiter with single-entry output stage and read-return ID pipe.
// Optional perf counters enabled by defining DPRAM_ARB_PERF_EN.
module dpram_port_arb
   import dpram_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int RD_LAT  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   dpram_port_arb_if.slave  bus
`ifdef DPRAM_ARB_PERF_EN
   ,
   input  logic                          perf_clr,
   output logic [NUM_REQ*PERF_CNT_W-1:0] perf_grant_cnt,
   output logic [PERF_CNT_W-1:0]         perf_stall_cnt
`endif
);
   localparam int IDW = $clog2(NUM_REQ);

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [IDW-1:0]    id;
   } stage_s;

   stage_s                        r_stg;
   logic                          r_vld;
   logic [IDW-1:0]                r_ptr;
   logic [RD_LAT-1:0]             r_vld_pipe;
   logic [RD_LAT-1:0][IDW-1:0]    r_id_pipe;

   logic                          w_free;
   logic                          w_acc;
   logic                          w_any;
   logic                          w_rd_push;
   logic [NUM_REQ-1:0]            w_gnt;
   logic [IDW-1:0]                w_idx;

   assign w_free = !r_vld || bus.mem_ready;

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .i_req (bus.req_valid),
      .i_ptr (r_ptr),
      .o_gnt (w_gnt),
      .o_idx (w_idx),
      .o_any (w_any)
   );

   assign bus.req_ready = w_free ? w_gnt : '0;
   assign w_acc         = w_free && w_any;

   // Stage only moves when free; a stalled beat holds everything including ptr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld <= 1'b0;
         r_stg <= '0;
         r_ptr <= '0;
      end else if (w_free) begin
         r_vld <= w_acc;
         if (w_acc) begin
            r_stg.we   <= bus.req_we[w_idx];
            r_stg.addr <= bus.req_addr[w_idx*ADDR_W +: ADDR_W];
            r_stg.data <= bus.req_data[w_idx*DATA_W +: DATA_W];
            r_stg.id   <= w_idx;
            r_ptr      <= (w_idx == IDW'(NUM_REQ-1)) ? '0 : w_idx + 1'b1;
         end
      end
   end

   assign bus.mem_valid = r_vld;
   assign bus.mem_we    = r_stg.we;
   assign bus.mem_addr  = r_stg.addr;
   assign bus.mem_data  = r_stg.data;

   assign w_rd_push = r_vld && bus.mem_ready && !r_stg.we;

   // ID pipe is aligned so its exit coincides with mem_q being valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld_pipe <= '0;
         r_id_pipe  <= '0;
      end else begin
         r_vld_pipe[0] <= w_rd_push;
         r_id_pipe[0]  <= r_stg.id;
         for (int k = 1; k < RD_LAT; k++) begin
            r_vld_pipe[k] <= r_vld_pipe[k-1];
            r_id_pipe[k]  <= r_id_pipe[k-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rsp_valid <= '0;
         bus.rsp_data  <= '0;
      end else begin
         bus.rsp_valid <= '0;
         if (r_vld_pipe[RD_LAT-1]) begin
            bus.rsp_valid[r_id_pipe[RD_LAT-1]] <= 1'b1;
            bus.rsp_data                       <= bus.mem_q;
         end
      end
   end

`ifdef DPRAM_ARB_PERF_EN
   logic [NUM_REQ-1:0][PERF_CNT_W-1:0] r_gcnt;
   logic [PERF_CNT_W-1:0]              r_scnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gcnt <= '0;
         r_scnt <= '0;
      end else if (perf_clr) begin
         r_gcnt <= '0;
         r_scnt <= '0;
      end else begin
         for (int k = 0; k < NUM_REQ; k++)
            if (w_acc && (w_idx == IDW'(k))) r_gcnt[k] <= sat_inc(r_gcnt[k]);
         if (r_vld && !bus.mem_ready) r_scnt <= sat_inc(r_scnt);
      end
   end

   assign perf_grant_cnt = r_gcnt;
   assign perf_stall_cnt = r_scnt;
`else
   // Counters are not built in this configuration.
`endif
endmodule
